dem_switch_block: RTL and testbench

- One node of the tree-structured DEM encoder. It consumes the 1-bit output of pn_sequence_generator and splits an input thermometer count into two sub-codes for the next tree level.
- Each odd code puts one unit of imbalance on the top or bottom branch. The PN bit chooses the side (random mode), or a first-order shaping state chooses it with the PN bit breaking ties (shaping mode).
- Outputs are registered: one-cycle latency with valid qualification.

---
 rtl/dem_switch_block.sv | 135 +++++++++++++
 tb/tb_dem_switch_block.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dem_switch_block.sv
// dem_switch_block: one DEM tree node, splits a thermometer count into top/bottom sub-codes.
// Latency: one cycle from an accepted valid_i sample to valid_o and the data outputs.
// Backpressure: none; a new sample may be accepted on every rising edge of clk_i.
module dem_switch_block #(
    parameter int IN_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [IN_W-1:0]  code_i,
    input  logic             pn_seq_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    output logic [IN_W-1:0]  top_o,
    output logic [IN_W-1:0]  bot_o,
    output logic [1:0]       sel_o,
    output logic             pn_used_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] odd_cnt_o
);

    localparam logic [1:0] MODE_FIXED = 2'b00;
    localparam logic [1:0] MODE_SHAPE = 2'b10;
    localparam logic [1:0] ST_ZERO    = 2'b00;
    localparam logic [1:0] ST_POS     = 2'b01;
    localparam logic [1:0] ST_NEG     = 2'b11;
    localparam logic [1:0] SEL_POS    = 2'b01;
    localparam logic [1:0] SEL_NEG    = 2'b11;
    localparam logic [1:0] SEL_ZERO   = 2'b00;

    logic             r_valid;
    logic [IN_W-1:0]  r_top;
    logic [IN_W-1:0]  r_bot;
    logic [1:0]       r_sel;
    logic             r_pn_used;
    logic [1:0]       r_state;
    logic [1:0]       r_last_mode;
    logic [CNT_W-1:0] r_odd_cnt;

    logic             w_odd;
    logic [1:0]       w_state_eff;
    logic             w_s_pos;
    logic             w_pn_used;
    logic [1:0]       w_state_next;
    logic [IN_W:0]    w_x_ext;
    logic [IN_W:0]    w_x_plus;
    logic [IN_W:0]    w_x_minus;
    logic [IN_W-1:0]  w_top;
    logic [IN_W-1:0]  w_bot;
    logic [1:0]       w_sel;

    // Choose the sign s for this sample and the next shaping state.
    always_comb begin
        w_odd        = code_i[0];
        // A mode change clears the shaping state before s is derived.
        w_state_eff  = (mode_i != r_last_mode) ? ST_ZERO : r_state;
        w_s_pos      = 1'b1;
        w_pn_used    = 1'b0;
        w_state_next = w_state_eff;
        if (w_odd) begin
            case (mode_i)
                MODE_FIXED: begin
                    w_s_pos = 1'b1;
                end
                MODE_SHAPE: begin
                    if (w_state_eff == ST_ZERO) begin
                        w_s_pos      = pn_seq_i;
                        w_pn_used    = 1'b1;
                        w_state_next = pn_seq_i ? ST_POS : ST_NEG;
                    end else begin
                        // Cancel the stored imbalance: s = -state.
                        w_s_pos      = (w_state_eff == ST_NEG);
                        w_state_next = ST_ZERO;
                    end
                end
                default: begin
                    w_s_pos   = pn_seq_i;
                    w_pn_used = 1'b1;
                end
            endcase
        end
    end

    // Split the code at IN_W+1 bits so x+1 cannot overflow before the shift.
    always_comb begin
        w_x_ext   = {1'b0, code_i};
        w_x_plus  = w_x_ext + {{IN_W{1'b0}}, 1'b1};
        w_x_minus = w_x_ext - {{IN_W{1'b0}}, 1'b1};
        w_top     = code_i >> 1;
        w_bot     = code_i >> 1;
        w_sel     = SEL_ZERO;
        if (w_odd) begin
            w_top = w_s_pos ? w_x_plus[IN_W:1]  : w_x_minus[IN_W:1];
            w_bot = w_s_pos ? w_x_minus[IN_W:1] : w_x_plus[IN_W:1];
            w_sel = w_s_pos ? SEL_POS : SEL_NEG;
        end
    end

    // Register outputs; state, last mode and statistics only advance on accepted samples.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid     <= 1'b0;
            r_top       <= '0;
            r_bot       <= '0;
            r_sel       <= SEL_ZERO;
            r_pn_used   <= 1'b0;
            r_state     <= ST_ZERO;
            r_last_mode <= MODE_FIXED;
            r_odd_cnt   <= '0;
        end else begin
            r_valid   <= valid_i;
            r_pn_used <= valid_i & w_pn_used;
            if (valid_i) begin
                r_top       <= w_top;
                r_bot       <= w_bot;
                r_sel       <= w_sel;
                r_state     <= w_state_next;
                r_last_mode <= mode_i;
                if (w_odd && (r_odd_cnt != {CNT_W{1'b1}})) begin
                    r_odd_cnt <= r_odd_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign valid_o   = r_valid;
    assign top_o     = r_top;
    assign bot_o     = r_bot;
    assign sel_o     = r_sel;
    assign pn_used_o = r_pn_used;
    assign state_o   = r_state;
    assign odd_cnt_o = r_odd_cnt;

endmodule

// File: tb/tb_dem_switch_block.sv
// Directed bench for dem_switch_block with IN_W=4 and a 3-bit odd counter.
module tb_dem_switch_block;

    localparam int IN_W  = 4;
    localparam int CNT_W = 3;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b0;
    logic             valid_i = 1'b0;
    logic [IN_W-1:0]  code_i = '0;
    logic             pn_seq_i = 1'b0;
    logic [1:0]       mode_i = 2'b00;
    logic             valid_o;
    logic [IN_W-1:0]  top_o;
    logic [IN_W-1:0]  bot_o;
    logic [1:0]       sel_o;
    logic             pn_used_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] odd_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    dem_switch_block #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .valid_i   (valid_i),
        .code_i    (code_i),
        .pn_seq_i  (pn_seq_i),
        .mode_i    (mode_i),
        .valid_o   (valid_o),
        .top_o     (top_o),
        .bot_o     (bot_o),
        .sel_o     (sel_o),
        .pn_used_o (pn_used_o),
        .state_o   (state_o),
        .odd_cnt_o (odd_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample at the falling edge, then sample just after the rising edge.
    task automatic step(input logic v, input logic [IN_W-1:0] c, input logic [1:0] m, input logic pn);
        @(negedge clk_i);
        valid_i  = v;
        code_i   = c;
        mode_i   = m;
        pn_seq_i = pn;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [IN_W-1:0] t,
                           input logic [IN_W-1:0] b, input logic [1:0] s, input logic pu,
                           input logic [1:0] st);
        chk({tag, ".valid"}, 16'(valid_o), 16'(v));
        chk({tag, ".top"}, 16'(top_o), 16'(t));
        chk({tag, ".bot"}, 16'(bot_o), 16'(b));
        chk({tag, ".sel"}, 16'(sel_o), 16'(s));
        chk({tag, ".pn_used"}, 16'(pn_used_o), 16'(pu));
        chk({tag, ".state"}, 16'(state_o), 16'(st));
    endtask

    initial begin
        // Reset state
        reset_i = 1'b1;
        #1;
        chk_out("rst", 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 2'b00);
        chk("rst.cnt", 16'(odd_cnt_o), 16'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // 1: fixed mode, code 7 then 6 (pn irrelevant)
        step(1'b1, 4'd7, 2'b00, 1'b0);
        chk_out("t1a", 1'b1, 4'd4, 4'd3, 2'b01, 1'b0, 2'b00);
        step(1'b1, 4'd6, 2'b00, 1'b1);
        chk_out("t1b", 1'b1, 4'd3, 4'd3, 2'b00, 1'b0, 2'b00);
        chk("t1.cnt", 16'(odd_cnt_o), 16'd1);

        // 2: random mode, full-scale code
        step(1'b1, 4'd15, 2'b01, 1'b0);
        chk_out("t2a", 1'b1, 4'd7, 4'd8, 2'b11, 1'b1, 2'b00);
        step(1'b1, 4'd15, 2'b01, 1'b1);
        chk_out("t2b", 1'b1, 4'd8, 4'd7, 2'b01, 1'b1, 2'b00);
        chk("t2.cnt", 16'(odd_cnt_o), 16'd3);
        // mode 11 behaves as random
        step(1'b1, 4'd1, 2'b11, 1'b0);
        chk_out("t2c", 1'b1, 4'd0, 4'd1, 2'b11, 1'b1, 2'b00);
        // zero code
        step(1'b1, 4'd0, 2'b01, 1'b1);
        chk_out("t2d", 1'b1, 4'd0, 4'd0, 2'b00, 1'b0, 2'b00);

        // 3: shaping mode, code 5 with pn 1,1,0,0
        step(1'b1, 4'd5, 2'b10, 1'b1);
        chk_out("t3a", 1'b1, 4'd3, 4'd2, 2'b01, 1'b1, 2'b01);
        step(1'b1, 4'd5, 2'b10, 1'b1);
        chk_out("t3b", 1'b1, 4'd2, 4'd3, 2'b11, 1'b0, 2'b00);
        step(1'b1, 4'd5, 2'b10, 1'b0);
        chk_out("t3c", 1'b1, 4'd2, 4'd3, 2'b11, 1'b1, 2'b11);
        step(1'b1, 4'd5, 2'b10, 1'b0);
        chk_out("t3d", 1'b1, 4'd3, 4'd2, 2'b01, 1'b0, 2'b00);
        chk("t3.cnt", 16'(odd_cnt_o), 16'd7);

        // 4: leave state=+1, switch to random and back to shaping
        step(1'b1, 4'd1, 2'b10, 1'b1);
        chk_out("t4a", 1'b1, 4'd1, 4'd0, 2'b01, 1'b1, 2'b01);
        step(1'b1, 4'd3, 2'b01, 1'b0);
        chk_out("t4b", 1'b1, 4'd1, 4'd2, 2'b11, 1'b1, 2'b00);
        step(1'b1, 4'd3, 2'b10, 1'b0);
        chk_out("t4c", 1'b1, 4'd1, 4'd2, 2'b11, 1'b1, 2'b11);

        // 5: valid (even, state held), idle, valid, then reset mid-cycle
        step(1'b1, 4'd4, 2'b10, 1'b1);
        chk_out("t5a", 1'b1, 4'd2, 4'd2, 2'b00, 1'b0, 2'b11);
        step(1'b0, 4'd9, 2'b10, 1'b0);
        chk_out("t5idle", 1'b0, 4'd2, 4'd2, 2'b00, 1'b0, 2'b11);
        chk("t5idle.cnt", 16'(odd_cnt_o), 16'd7);
        step(1'b1, 4'd9, 2'b10, 1'b1);
        chk_out("t5b", 1'b1, 4'd5, 4'd4, 2'b01, 1'b0, 2'b00);
        @(negedge clk_i);
        valid_i  = 1'b1;
        code_i   = 4'd11;
        mode_i   = 2'b01;
        pn_seq_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        chk_out("t5rst", 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 2'b00);
        chk("t5rst.cnt", 16'(odd_cnt_o), 16'd0);
        @(posedge clk_i);
        #1;
        chk("t5drop.valid", 16'(valid_o), 16'd0);
        @(negedge clk_i);
        valid_i = 1'b0;
        reset_i = 1'b0;
        step(1'b1, 4'd3, 2'b00, 1'b0);
        chk_out("t5rel", 1'b1, 4'd2, 4'd1, 2'b01, 1'b0, 2'b00);
        chk("t5rel.cnt", 16'(odd_cnt_o), 16'd1);

        // 6: odd counter saturation at 7 (nine more odd codes)
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 4'd13, 2'b01, i[0]);
            chk($sformatf("t6.cnt%0d", i), 16'(odd_cnt_o), (i + 2 > 7) ? 16'd7 : 16'(i + 2));
        end
        step(1'b0, 4'd0, 2'b01, 1'b0);
        chk("t6.valid", 16'(valid_o), 16'd0);
        chk("t6.pn_used", 16'(pn_used_o), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
